psp_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares one system memory port between NUM_REQ requesters (core instruction/data ports, or multiple cores in psp_system).
- Sits between the per-core memory requesters and the single backing memory/bus.
- Allows one outstanding transaction at a time. Includes a response-timeout watchdog and sticky protocol-error flags, so bench and system monitors can halt on a hang.

---
 rtl/psp_mem_arbiter_pkg.sv | 17 +
 rtl/psp_mem_arbiter_rr_picker.sv | 28 ++
 rtl/psp_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_psp_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psp_mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package psp_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RESP
  } arb_state_t;

  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEADBEEF;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psp_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward, wrapping.
module psp_rr_picker
  import psp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   grant_id
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    any      = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/psp_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters, one
// outstanding transaction at a time, with response watchdog and sticky error flags.
module psp_mem_arbiter
  import psp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_wmask,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_err,
  output logic                          mem_valid,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_wmask,
  input  logic                          mem_ready,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          timeout_err,
  output logic                          proto_err
);

  localparam int unsigned IDX_W  = idx_width(NUM_REQ);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t        state, state_next;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_id;
  logic [IDX_W-1:0]  rr_next;
  logic [WDOG_W-1:0] wdog;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_id;
  logic              timeout_hit;

  psp_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req_valid),
    .rr_ptr   (rr_ptr),
    .any      (pick_any),
    .grant_id (pick_id)
  );

  assign timeout_hit = (TIMEOUT != 0) && (state == ARB_WAIT_RESP) && (wdog == WDOG_LAST);
  assign rr_next     = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_next = state;
    req_ready  = '0;
    mem_valid  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_ISSUE;
          req_ready[pick_id] = !reset;
        end
      end
      ARB_ISSUE: begin
        mem_valid = !reset;
        if (mem_ready) state_next = ARB_WAIT_RESP;
      end
      ARB_WAIT_RESP: begin
        if (mem_rvalid || timeout_hit) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      wdog        <= '0;
      resp_valid  <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state      <= state_next;
      resp_valid <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_id;
            mem_we    <= req_we[pick_id];
            mem_addr  <= req_addr[pick_id*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[pick_id*DATA_W +: DATA_W];
            mem_wmask <= req_wmask[pick_id*MASK_W +: MASK_W];
          end
        end
        ARB_ISSUE: begin
          if (mem_ready) wdog <= '0;
        end
        ARB_WAIT_RESP: begin
          wdog <= wdog + 1'b1;
          // A real response wins over a watchdog expiry landing in the same cycle.
          if (mem_rvalid) begin
            resp_rdata           <= mem_we ? '0 : mem_rdata;
            resp_err             <= 1'b0;
            resp_valid[grant_id] <= 1'b1;
            rr_ptr               <= rr_next;
          end else if (timeout_hit) begin
            resp_rdata           <= DATA_W'(ARB_TIMEOUT_DATA);
            resp_err             <= 1'b1;
            resp_valid[grant_id] <= 1'b1;
            timeout_err          <= 1'b1;
            rr_ptr               <= rr_next;
          end
        end
        default: ;
      endcase
      if (mem_rvalid && state != ARB_WAIT_RESP) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psp_mem_arbiter.sv
// Directed, table-driven bench for psp_mem_arbiter and its round-robin picker.
module tb_psp_mem_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_we, req_ready, resp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*MW-1:0]  req_wmask;
  logic [DW-1:0]     resp_rdata, mem_wdata, mem_rdata;
  logic              resp_err, mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_wmask;
  logic              timeout_err, proto_err;

  logic [3:0] pk_req;
  logic [1:0] pk_ptr, pk_gid;
  logic       pk_any;

  always #5 clk = ~clk;

  psp_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  psp_rr_picker #(.NUM_REQ(4), .IDX_W(2)) u_pick (
    .req(pk_req), .rr_ptr(pk_ptr), .any(pk_any), .grant_id(pk_gid)
  );

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic       any;
    logic [1:0] gid;
  } pick_vec_t;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
  } txn_t;

  pick_vec_t pvec[10];
  txn_t      txns[4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
    req_valid[r]          = 1'b1;
    req_we[r]             = we;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = wdata;
    req_wmask[r*MW +: MW] = wmask;
  endtask

  task automatic chk_zero_outputs(input string tag);
    settle();
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  // Fixed-latency single transaction: grant, issue, response next cycle, resp_valid after.
  task automatic run_txn(input txn_t t);
    set_req(t.id, t.we, t.addr, t.wdata, t.wmask);
    mem_ready = 1'b1;
    settle();
    chk("txn_req_ready", req_ready, oh(t.id));
    chk("txn_mem_valid_idle", mem_valid, 0);
    tick();
    req_valid = '0;
    settle();
    chk("txn_mem_valid", mem_valid, 1);
    chk("txn_mem_we", mem_we, t.we);
    chk("txn_mem_addr", mem_addr, t.addr);
    chk("txn_mem_wdata", mem_wdata, t.wdata);
    chk("txn_mem_wmask", mem_wmask, t.wmask);
    chk("txn_req_ready_issue", req_ready, 0);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = t.mrdata;
    settle();
    chk("txn_resp_early", resp_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("txn_resp_valid", resp_valid, oh(t.id));
    chk("txn_resp_rdata", resp_rdata, t.exp_rdata);
    chk("txn_resp_err", resp_err, 0);
    tick();
  endtask

  initial begin
    logic [31:0] ca[2];
    int exp_g, prev_g;

    pvec[0] = '{4'b0000, 2'd0, 1'b0, 2'd0};
    pvec[1] = '{4'b0001, 2'd0, 1'b1, 2'd0};
    pvec[2] = '{4'b0001, 2'd3, 1'b1, 2'd0};
    pvec[3] = '{4'b1010, 2'd0, 1'b1, 2'd1};
    pvec[4] = '{4'b1010, 2'd2, 1'b1, 2'd3};
    pvec[5] = '{4'b1010, 2'd3, 1'b1, 2'd3};
    pvec[6] = '{4'b1010, 2'd1, 1'b1, 2'd1};
    pvec[7] = '{4'b1111, 2'd2, 1'b1, 2'd2};
    pvec[8] = '{4'b1000, 2'd1, 1'b1, 2'd3};
    pvec[9] = '{4'b0110, 2'd3, 1'b1, 2'd1};

    txns[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'hCAFE_F00D, 32'hCAFE_F00D};
    txns[1] = '{1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 32'h5555_5555, 32'h0};
    txns[2] = '{1, 1'b0, 32'h0000_3000, 32'h0,         4'b0000, 32'hA5A5_0001, 32'hA5A5_0001};
    txns[3] = '{0, 1'b1, 32'h0000_FFFC, 32'hDEAD_0000, 4'b1100, 32'h0BAD_0BAD, 32'h0};

    pk_req = '0;
    pk_ptr = '0;
    do_reset();
    chk_zero_outputs("reset0");

    for (int i = 0; i < 10; i++) begin
      pk_req = pvec[i].req;
      pk_ptr = pvec[i].ptr;
      #1;
      chk("pick_any", pk_any, pvec[i].any);
      chk("pick_gid", pk_gid, pvec[i].gid);
    end

    for (int i = 0; i < 4; i++) run_txn(txns[i]);

    do_reset();
    chk_zero_outputs("reset1");

    // Contention: both requesters held, each read returns its own address.
    ca[0] = 32'h0000_0100;
    ca[1] = 32'h0000_0204;
    set_req(0, 1'b0, ca[0], 32'h0, 4'h0);
    set_req(1, 1'b0, ca[1], 32'h0, 4'h0);
    mem_ready = 1'b1;
    prev_g = 0;
    for (int t = 0; t < 4; t++) begin
      exp_g = t % 2;
      settle();
      chk("cont_req_ready", req_ready, oh(exp_g));
      if (t > 0) begin
        chk("cont_resp_valid", resp_valid, oh(prev_g));
        chk("cont_resp_rdata", resp_rdata, ca[prev_g]);
      end
      tick();
      settle();
      chk("cont_mem_addr", mem_addr, ca[exp_g]);
      chk("cont_ready_issue", req_ready, 0);
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = ca[exp_g];
      tick();
      mem_rvalid = 1'b0;
      prev_g = exp_g;
    end
    req_valid = '0;
    settle();
    chk("cont_resp_last", resp_valid, oh(1));
    chk("cont_rdata_last", resp_rdata, ca[1]);
    chk("cont_ready_last", req_ready, 0);
    tick();

    // Watchdog timeout: no response ever arrives.
    do_reset();
    set_req(0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    mem_ready = 1'b1;
    settle();
    chk("to_req_ready", req_ready, oh(0));
    tick();
    req_valid = '0;
    settle();
    chk("to_mem_valid", mem_valid, 1);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      settle();
      chk("to_no_early_resp", resp_valid, 0);
      tick();
    end
    settle();
    chk("to_resp_valid", resp_valid, oh(0));
    chk("to_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("to_resp_err", resp_err, 1);
    chk("to_timeout_err", timeout_err, 1);
    tick();
    tick();
    tick();
    chk("to_sticky", timeout_err, 1);
    chk("to_proto_before", proto_err, 0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("to_late_proto", proto_err, 1);
    chk("to_late_no_resp", resp_valid, 0);
    chk("to_sticky2", timeout_err, 1);

    // Reset while waiting for a response.
    do_reset();
    run_txn(txns[0]);
    set_req(1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    mem_ready = 1'b1;
    settle();
    chk("rst_req_ready", req_ready, oh(1));
    tick();
    req_valid = '0;
    tick();
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    settle();
    chk("rst_no_resp0", resp_valid, 0);
    chk("rst_proto_clear", proto_err, 0);
    chk("rst_mem_valid", mem_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("rst_no_resp1", resp_valid, 0);
    chk("rst_proto_set", proto_err, 1);
    chk("rst_timeout_clear", timeout_err, 0);
    set_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    settle();
    chk("rst_rr_ptr", req_ready, oh(0));
    tick();

    // ISSUE stall: mem_ready low for five cycles.
    do_reset();
    set_req(0, 1'b1, 32'h0000_0040, 32'hA1B2_C3D4, 4'b0101);
    settle();
    chk("stall_req_ready", req_ready, oh(0));
    tick();
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_mem_valid", mem_valid, 1);
      chk("stall_mem_we", mem_we, 1);
      chk("stall_mem_addr", mem_addr, 32'h0000_0040);
      chk("stall_mem_wdata", mem_wdata, 32'hA1B2_C3D4);
      chk("stall_mem_wmask", mem_wmask, 4'b0101);
      chk("stall_req_ready", req_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    chk("stall_mem_valid_acc", mem_valid, 1);
    tick();
    mem_ready  = 1'b0;
    req_valid  = '0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0077;
    settle();
    chk("stall_wait_no_valid", mem_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("stall_resp_valid", resp_valid, oh(0));
    chk("stall_resp_rdata", resp_rdata, 0);
    chk("stall_resp_err", resp_err, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
